// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer
//   Control unit of the SAP-1 computer. A one-hot six-state ring counter
//   (T1..T6) is combined with the IR opcode nibble to produce the 12-bit
//   control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}.
//   When an HLT opcode reaches T4, the machine halts.
//
// Ports
//   CLK_n    in   1             system clock; all state updates on its rising edge
//   CLR_n    in   1             asynchronous active-low clear (ring -> T1, HLT -> 0)
//   opcode   in   OPCODE_WIDTH  IR upper nibble, used combinationally
//   con      out  12            control word, bit 11 = Cp
//   Cp..Lo_n out  1 each        individual copies of the con bits
//   t_state  out  6             one-hot ring state, bit0 = T1
//   HLT      out  1             machine halted
//
// Build option
//   SAP1_VARIABLE_MACHINE_CYCLE_EN : when defined, the ring returns to T1
//   right after the last useful T-state of each instruction
//   (LDA 5, ADD/SUB 6, OUT 4, undefined 3). When it is not defined, every
//   instruction takes the fixed six states.

module sap1_controller_sequencer #(
    parameter int                        OPCODE_WIDTH = 4,
    parameter logic [OPCODE_WIDTH-1:0]   OP_LDA       = 4'b0000,
    parameter logic [OPCODE_WIDTH-1:0]   OP_ADD       = 4'b0001,
    parameter logic [OPCODE_WIDTH-1:0]   OP_SUB       = 4'b0010,
    parameter logic [OPCODE_WIDTH-1:0]   OP_OUT       = 4'b1110,
    parameter logic [OPCODE_WIDTH-1:0]   OP_HLT       = 4'b1111
) (
    input  logic                    CLK_n,
    input  logic                    CLR_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [11:0]             con,
    output logic                    Cp,
    output logic                    Ep,
    output logic                    Lm_n,
    output logic                    CE_n,
    output logic                    Li_n,
    output logic                    Ei_n,
    output logic                    La_n,
    output logic                    Ea,
    output logic                    Su,
    output logic                    Eu,
    output logic                    Lb_n,
    output logic                    Lo_n,
    output logic [5:0]              t_state,
    output logic                    HLT
);

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } t_state_e;

    // Control words
    localparam logic [11:0] CON_NOP     = 12'h3E3;
    localparam logic [11:0] CON_FETCH1  = 12'h5E3;  // Ep, Lm_n active
    localparam logic [11:0] CON_FETCH2  = 12'hBE3;  // Cp
    localparam logic [11:0] CON_FETCH3  = 12'h263;  // CE_n, Li_n active
    localparam logic [11:0] CON_IR_MAR  = 12'h1A3;  // Ei_n, Lm_n active
    localparam logic [11:0] CON_LDA_T5  = 12'h2C3;  // CE_n, La_n active
    localparam logic [11:0] CON_ALU_T5  = 12'h2E1;  // CE_n, Lb_n active
    localparam logic [11:0] CON_ADD_T6  = 12'h3C7;  // Eu, La_n active
    localparam logic [11:0] CON_SUB_T6  = 12'h3CF;  // Su, Eu, La_n active
    localparam logic [11:0] CON_OUT_T4  = 12'h3F2;  // Ea, Lo_n active

    t_state_e    state_q, state_d;
    logic        hlt_q, hlt_d;
    logic [11:0] con_d;
    logic [2:0]  last_step;   // index (3..6) of the final T-state of this instruction

    // Last T-state of the current instruction. HLT keeps the full length;
    // it leaves the ring through the halt path in T4 instead.
`ifdef SAP1_VARIABLE_MACHINE_CYCLE_EN
    always_comb begin
        last_step = 3'd3;
        if (opcode == OP_LDA)
            last_step = 3'd5;
        else if (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_HLT)
            last_step = 3'd6;
        else if (opcode == OP_OUT)
            last_step = 3'd4;
    end
`else
    always_comb begin
        last_step = 3'd6;
    end
`endif

    always_ff @(posedge CLK_n or negedge CLR_n) begin
        if (!CLR_n) begin
            state_q <= ST_T1;
            hlt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hlt_q   <= hlt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hlt_d   = hlt_q;
        con_d   = CON_NOP;

        if (hlt_q) begin
            // Frozen: ring holds, PC not incremented, nothing strobed.
            state_d = state_q;
            con_d   = CON_NOP;
        end else begin
            case (state_q)
                ST_T1: begin
                    con_d   = CON_FETCH1;
                    state_d = ST_T2;
                end
                ST_T2: begin
                    con_d   = CON_FETCH2;
                    state_d = ST_T3;
                end
                ST_T3: begin
                    con_d   = CON_FETCH3;
                    state_d = (last_step <= 3'd3) ? ST_T1 : ST_T4;
                end
                ST_T4: begin
                    if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB)
                        con_d = CON_IR_MAR;
                    else if (opcode == OP_OUT)
                        con_d = CON_OUT_T4;
                    state_d = (last_step <= 3'd4) ? ST_T1 : ST_T5;
                    // Halt takes effect on this edge; the ring stays in T4.
                    if (opcode == OP_HLT) begin
                        hlt_d   = 1'b1;
                        state_d = ST_T4;
                    end
                end
                ST_T5: begin
                    if (opcode == OP_LDA)
                        con_d = CON_LDA_T5;
                    else if (opcode == OP_ADD || opcode == OP_SUB)
                        con_d = CON_ALU_T5;
                    state_d = (last_step <= 3'd5) ? ST_T1 : ST_T6;
                end
                ST_T6: begin
                    if (opcode == OP_ADD)
                        con_d = CON_ADD_T6;
                    else if (opcode == OP_SUB)
                        con_d = CON_SUB_T6;
                    state_d = ST_T1;
                end
                default: begin
                    // Not reachable from reset; restart the ring if it ever happens.
                    con_d   = CON_NOP;
                    state_d = ST_T1;
                end
            endcase
        end
    end

    assign con     = con_d;
    assign {Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n} = con_d;
    assign t_state = state_q;
    assign HLT     = hlt_q;

endmodule
